// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 64-bit ALU, with a registered response slot.
// Round-robin grant on contention, one operation per cycle when the consumer keeps up.

module alu (
    input  logic [3:0]  i_ctl,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_result,
    output logic        o_zero
);

    always_comb begin
        o_result = '0;
        case (i_ctl)
            4'b0000: o_result = i_a & i_b;
            4'b0001: o_result = i_a | i_b;
            4'b0010: o_result = i_a + i_b;
            4'b0110: o_result = i_a - i_b;
            4'b0111: o_result = i_b;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

module alu_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    // last_served starts opposite the favoured requester so it wins the first tie.
    localparam logic LastInit = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        r_last;
    logic        r_id;
    logic [63:0] r_result;
    logic        r_zero;
    logic        r_err;

    logic        w_can_accept;
    logic        w_grant;
    logic        w_accept;
    logic [3:0]  w_op;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_legal;

    // Grant uses only valids and history, keeping req_ready off the op/operand paths.
    assign w_can_accept = (r_state == StEmpty) || rsp_ready;
    assign w_grant      = (&req_valid) ? ~r_last : req_valid[1];
    assign w_accept     = w_can_accept && (|req_valid) && !reset;

    always_comb begin
        w_state_d = r_state;
        req_ready = 2'b00;
        if (w_accept) begin
            req_ready = w_grant ? 2'b10 : 2'b01;
        end
        unique case (r_state)
            StEmpty: if (w_accept) w_state_d = StFull;
            StFull:  if (rsp_ready && !w_accept) w_state_d = StEmpty;
            default: w_state_d = StEmpty;
        endcase
    end

    assign w_op = w_grant ? req1_op : req0_op;
    assign w_a  = w_grant ? req1_a  : req0_a;
    assign w_b  = w_grant ? req1_b  : req0_b;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    alu u_alu (
        .i_ctl    (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last   <= LastInit;
            r_id     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_last   <= w_grant;
            r_id     <= w_grant;
            r_result <= w_legal ? w_alu_result : 64'd0;
            r_zero   <= w_legal ? w_alu_zero : 1'b0;
            r_err    <= !w_legal;
        end
    end

    assign rsp_valid  = (r_state == StFull);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: driver models grant and pushes hand-computed results,
// monitor pops and compares every response the consumer takes.

module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    alu_arbiter #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   served[2];

    // Pending vectors, applied to the pins by step() just after a falling edge.
    logic [3:0]  n_op[2];
    logic [63:0] n_a[2], n_b[2], e_res[2];
    logic        e_zero[2], e_err[2];

    // Reference state for the arbiter.
    logic m_full = 1'b0;
    logic m_last = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] res, input logic z,
                           input logic e);
        n_op[i] = op; n_a[i] = a; n_b[i] = b;
        e_res[i] = res; e_zero[i] = z; e_err[i] = e;
    endtask

    task automatic step(input logic [1:0] vld, input logic rr);
        logic       ca, g;
        logic [1:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        req0_op = n_op[0]; req0_a = n_a[0]; req0_b = n_b[0];
        req1_op = n_op[1]; req1_a = n_a[1]; req1_b = n_b[1];
        req_valid = vld;
        rsp_ready = rr;
        #1;
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
        ca = !m_full || rr;
        g  = (&vld) ? ~m_last : vld[1];
        exp_rdy = (ca && (|vld)) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
        if (exp_rdy != 2'b00) begin
            e.id = g; e.res = e_res[g]; e.zero = e_zero[g]; e.err = e_err[g];
            q.push_back(e);
            m_last = g;
            m_full = 1'b1;
        end else if (rr) begin
            m_full = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rsp_valid",  {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id",     {63'd0, rsp_id}, 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_zero",   {63'd0, rsp_zero}, 64'd0);
        chk("rst_rsp_err",    {63'd0, rsp_err}, 64'd0);
        chk("rst_req_ready",  {62'd0, req_ready}, 64'd0);
    endtask

    // Monitor: compare each response in the cycle the consumer takes it.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rsp: got id=%0d result=%0h expected none",
                         rsp_id, rsp_result);
            end else begin
                e = q.pop_front();
                chk("rsp_id",     {63'd0, rsp_id}, {63'd0, e.id});
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_zero",   {63'd0, rsp_zero}, {63'd0, e.zero});
                chk("rsp_err",    {63'd0, rsp_err}, {63'd0, e.err});
                served[rsp_id]++;
            end
        end
    end

    initial begin
        reset = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
        req0_op = 4'b0010; req1_op = 4'b0010;
        req0_a = 64'd1; req0_b = 64'd1; req1_a = 64'd1; req1_b = 64'd1;
        served[0] = 0; served[1] = 0;
        #1 reset = 1'b1;
        #1 chk_reset_outputs();
        @(posedge clk); #2 reset = 1'b0;

        // Tie after reset: requester 0 first, then requester 1.
        set_req(0, 4'b0000, 64'd1206, 64'd4404, 64'd52, 1'b0, 1'b0);
        set_req(1, 4'b0110, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);

        set_req(0, 4'b0010, 64'd4781, 64'd1346, 64'd6127, 1'b0, 1'b0);
        step(2'b01, 1'b1);
        set_req(1, 4'b0011, 64'd5, 64'd6, 64'd0, 1'b0, 1'b1);
        step(2'b10, 1'b1);
        set_req(0, 4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0);
        step(2'b01, 1'b1);
        set_req(1, 4'b0111, 64'd123, 64'hDEAD, 64'hDEAD, 1'b0, 1'b0);
        step(2'b10, 1'b1);
        set_req(0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0, 1'b0);
        step(2'b01, 1'b1);
        set_req(1, 4'b0110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0);
        step(2'b10, 1'b1);

        // Stall: held response must not move and nothing may be accepted.
        set_req(1, 4'b0110, 64'd2108, 64'd2669, -64'd561, 1'b0, 1'b0);
        step(2'b10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(2'b11, 1'b0);
            chk("stall_result", rsp_result, -64'd561);
        end
        set_req(0, 4'b0010, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0);
        step(2'b01, 1'b1);

        // Fairness under continuous contention.
        step(2'b00, 1'b1);
        served[0] = 0; served[1] = 0;
        set_req(0, 4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0);
        set_req(1, 4'b0111, 64'd7, 64'd99, 64'd99, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(2'b11, 1'b1);
        step(2'b00, 1'b1);
        chk("served0", 64'(served[0]), 64'd5);
        chk("served1", 64'(served[1]), 64'd5);

        // Reset while holding a response drops it without a clock edge.
        set_req(0, 4'b0010, 64'd100, 64'd200, 64'd300, 1'b0, 1'b0);
        step(2'b01, 1'b0);
        step(2'b00, 1'b0);
        req_valid = 2'b11;
        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        q.delete();
        m_full = 1'b0;
        m_last = 1'b1;
        req_valid = 2'b00;
        @(posedge clk); #2 reset = 1'b0;
        set_req(1, 4'b0110, 64'd1000, 64'd1, 64'd999, 1'b0, 1'b0);
        step(2'b10, 1'b1);
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
